// File: rtl/operand_loader.sv
// Byte-stream front end for the registered 16-bit adder: assembles operand A, operand B
// and a carry-in from four valid/ready bytes, then strobes the operand registers once.
module operand_loader #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_cin,
    input  logic        flush,
    output logic [15:0] d_a,
    output logic [15:0] d_b,
    output logic        en_a,
    output logic        en_b,
    output logic        cin,
    output logic        result_valid
);

    typedef enum logic [2:0] {
        S_A0,
        S_A1,
        S_B0,
        S_B1,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_live;
    logic [15:0] r_d_a;
    logic [15:0] r_d_b;
    logic        r_cin;
    logic        w_collect;
    logic        w_xfer;
    logic        w_hi;

    // r_live holds in_ready low until the first edge after reset is released.
    always_comb begin
        w_collect    = (r_state == S_A0) || (r_state == S_A1) ||
                       (r_state == S_B0) || (r_state == S_B1);
        in_ready     = r_live && w_collect;
        w_xfer       = in_valid && in_ready && !flush;
        w_hi         = ((r_state == S_A1) || (r_state == S_B1)) ^ BIG_ENDIAN;
        en_a         = (r_state == S_COMMIT) && !flush;
        en_b         = en_a;
        result_valid = (r_state == S_DONE);
        d_a          = r_d_a;
        d_b          = r_d_b;
        cin          = r_cin;
        w_next       = r_state;
        if (flush) begin
            w_next = S_A0;
        end else begin
            case (r_state)
                S_A0:     if (w_xfer) w_next = S_A1;
                S_A1:     if (w_xfer) w_next = S_B0;
                S_B0:     if (w_xfer) w_next = S_B1;
                S_B1:     if (w_xfer) w_next = S_COMMIT;
                S_COMMIT: w_next = S_DONE;
                S_DONE:   w_next = S_A0;
                default:  w_next = S_A0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_A0;
            r_live  <= 1'b0;
            r_d_a   <= '0;
            r_d_b   <= '0;
            r_cin   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_xfer) begin
                if ((r_state == S_A0) || (r_state == S_A1)) begin
                    if (w_hi) r_d_a[15:8] <= in_data;
                    else      r_d_a[7:0]  <= in_data;
                end else begin
                    if (w_hi) r_d_b[15:8] <= in_data;
                    else      r_d_b[7:0]  <= in_data;
                end
                if (r_state == S_B1) r_cin <= in_cin;
            end
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: both byte orders side by side, a byte-level reference model
// checked every cycle, a vector table, directed corner sequences and a random phase.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_cin = 1'b0;
    logic        flush = 1'b0;

    logic        o0_ready, o0_en_a, o0_en_b, o0_cin, o0_rv;
    logic [15:0] o0_d_a, o0_d_b;
    logic        o1_ready, o1_en_a, o1_en_b, o1_cin, o1_rv;
    logic [15:0] o1_d_a, o1_d_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_loader #(.BIG_ENDIAN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(o0_ready),
        .in_cin(in_cin), .flush(flush), .d_a(o0_d_a), .d_b(o0_d_b), .en_a(o0_en_a),
        .en_b(o0_en_b), .cin(o0_cin), .result_valid(o0_rv)
    );

    operand_loader #(.BIG_ENDIAN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(o1_ready),
        .in_cin(in_cin), .flush(flush), .d_a(o1_d_a), .d_b(o1_d_b), .en_a(o1_en_a),
        .en_b(o1_en_b), .cin(o1_cin), .result_valid(o1_rv)
    );

    // Downstream operand registers and event counters fed by the DUT outputs.
    logic [15:0] rA0 = '0, rB0 = '0, rA1 = '0, rB1 = '0;
    int unsigned en_cnt = 0, rv_cnt = 0, cyc = 0, rv_last = 0, rv_prev = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o0_en_a) rA0 <= o0_d_a;
        if (o0_en_b) rB0 <= o0_d_b;
        if (o1_en_a) rA1 <= o1_d_a;
        if (o1_en_b) rB1 <= o1_d_b;
        if (o0_en_a && o0_en_b) en_cnt <= en_cnt + 1;
        if (o0_rv) begin
            rv_cnt  <= rv_cnt + 1;
            rv_prev <= rv_last;
            rv_last <= cyc;
        end
    end

    logic [16:0] sum0, sum1;
    assign sum0 = {1'b0, rA0} + {1'b0, rB0} + {16'd0, o0_cin};
    assign sum1 = {1'b0, rA1} + {1'b0, rB1} + {16'd0, o1_cin};

    // Reference model: bytes collected so far, post-collection phase, operand byte arrays
    // indexed [endianness][operand][byte significance].
    bit          m_live;
    int unsigned m_cnt, m_phase;
    logic [7:0]  m_op [2][2][2];
    logic        m_cin;

    function automatic logic [15:0] m_d(input int e, input int op);
        return {m_op[e][op][1], m_op[e][op][0]};
    endfunction

    task automatic model_reset();
        m_live = 0; m_cnt = 0; m_phase = 0; m_cin = 0;
        for (int e = 0; e < 2; e++)
            for (int o = 0; o < 2; o++)
                for (int h = 0; h < 2; h++) m_op[e][o][h] = '0;
    endtask

    task automatic model_step();
        int op, half;
        if (flush) begin
            m_phase = 0; m_cnt = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0; m_cnt = 0;
        end else if (in_valid && m_live) begin
            op = int'(m_cnt / 2);
            half = int'(m_cnt % 2);
            m_op[0][op][half]     = in_data;
            m_op[1][op][1 - half] = in_data;
            if (m_cnt == 3) begin
                m_cin = in_cin; m_phase = 1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        m_live = 1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic [4:0] exp_ctrl;
        logic       m_en;
        #1;
        m_en = (m_phase == 1) && !flush;
        exp_ctrl = {m_live && (m_phase == 0), m_en, m_en, m_phase == 2, m_cin};
        chk("ctrl_le", {o0_ready, o0_en_a, o0_en_b, o0_rv, o0_cin}, exp_ctrl);
        chk("ctrl_be", {o1_ready, o1_en_a, o1_en_b, o1_rv, o1_cin}, exp_ctrl);
        chk("d_a_le", o0_d_a, m_d(0, 0));
        chk("d_b_le", o0_d_b, m_d(0, 1));
        chk("d_a_be", o1_d_a, m_d(1, 0));
        chk("d_b_be", o1_d_b, m_d(1, 1));
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic c);
        bit acc;
        acc = 0;
        in_valid = 1'b1; in_data = b; in_cin = c;
        for (int g = 0; g < 20 && !acc; g++) begin
            acc = o0_ready;
            tick();
        end
        chk("handshake_accept", 64'(acc), 64'd1);
        in_valid = 1'b0; in_data = 8'($urandom); in_cin = 1'($urandom);
    endtask

    typedef struct {
        logic [7:0]  b [4];
        logic        cin;
        logic [15:0] da0, db0, da1, db1;
        logic [16:0] s0, s1;
    } vec_t;

    task automatic send_op(input vec_t v, input int unsigned stall);
        for (int i = 0; i < 4; i++) begin
            push_byte(v.b[i], (i == 3) ? v.cin : 1'($urandom));
            if (i < 3) repeat (stall) tick();
        end
        #1;
        chk("commit_en", {o0_en_a, o0_en_b, o1_en_a, o1_en_b}, 4'hF);
        chk("commit_da_le", o0_d_a, v.da0);
        chk("commit_db_le", o0_d_b, v.db0);
        chk("commit_da_be", o1_d_a, v.da1);
        chk("commit_db_be", o1_d_b, v.db1);
        chk("commit_cin", {o0_cin, o1_cin}, {v.cin, v.cin});
        tick();
        #1;
        chk("done_rv", {o0_rv, o1_rv, o0_ready}, 3'b110);
        chk("sum_le", sum0, v.s0);
        chk("sum_be", sum1, v.s1);
        tick();
        chk("ready_after", o0_ready, 1'b1);
    endtask

    vec_t        tbl [4];
    int unsigned e0, r0;

    initial begin
        tbl[0].b = '{8'h34, 8'h12, 8'h78, 8'h56}; tbl[0].cin = 1'b1;
        tbl[0].da0 = 16'h1234; tbl[0].db0 = 16'h5678; tbl[0].da1 = 16'h3412; tbl[0].db1 = 16'h7856;
        tbl[0].s0 = 17'h068AD; tbl[0].s1 = 17'h0AC69;
        tbl[1].b = '{8'hFF, 8'hFF, 8'h00, 8'h01}; tbl[1].cin = 1'b0;
        tbl[1].da0 = 16'hFFFF; tbl[1].db0 = 16'h0100; tbl[1].da1 = 16'hFFFF; tbl[1].db1 = 16'h0001;
        tbl[1].s0 = 17'h100FF; tbl[1].s1 = 17'h10000;
        tbl[2].b = '{8'hAA, 8'h00, 8'hBB, 8'h00}; tbl[2].cin = 1'b0;
        tbl[2].da0 = 16'h00AA; tbl[2].db0 = 16'h00BB; tbl[2].da1 = 16'hAA00; tbl[2].db1 = 16'hBB00;
        tbl[2].s0 = 17'h00165; tbl[2].s1 = 17'h16500;
        tbl[3].b = '{8'h01, 8'h80, 8'hFF, 8'h7F}; tbl[3].cin = 1'b1;
        tbl[3].da0 = 16'h8001; tbl[3].db0 = 16'h7FFF; tbl[3].da1 = 16'h0180; tbl[3].db1 = 16'hFF7F;
        tbl[3].s0 = 17'h10001; tbl[3].s1 = 17'h10100;

        model_reset();
        @(negedge clk);
        #1;
        chk("reset_outputs", {o0_ready, o0_en_a, o0_rv, o0_cin, o0_d_a, o0_d_b}, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_first_edge", {o0_ready, o1_ready}, 2'b00);
        tick();
        chk("ready_after_release", {o0_ready, o1_ready}, 2'b11);

        for (int i = 0; i < 4; i++) send_op(tbl[i], 0);

        e0 = en_cnt; r0 = rv_cnt;
        send_op(tbl[0], 3);
        chk("stall_en_pulses", en_cnt - e0, 1);
        chk("stall_rv_pulses", rv_cnt - r0, 1);

        // Flush after two bytes; the follow-up operand pair must be the only load.
        e0 = en_cnt;
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        send_op(tbl[2], 0);
        chk("flush_partial_en_pulses", en_cnt - e0, 1);

        // Flush while committing: no load and no result.
        r0 = rv_cnt; e0 = en_cnt;
        for (int i = 0; i < 4; i++) push_byte(tbl[3].b[i], tbl[3].cin);
        flush = 1'b1;
        #1;
        chk("flush_commit_en", {o0_en_a, o0_en_b, o1_en_a, o1_en_b}, 4'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_commit_no_rv", {o0_rv, o1_rv, o0_ready}, 3'b001);
        tick(); tick();
        chk("flush_commit_counts", {en_cnt - e0, rv_cnt - r0}, 64'd0);

        // Asynchronous reset mid-assembly with in_valid high.
        push_byte(8'hC3, 1'b1);
        push_byte(8'h3C, 1'b1);
        in_valid = 1'b1; in_data = 8'h77;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_ctrl", {o0_ready, o0_en_a, o0_en_b, o0_rv, o0_cin,
                               o1_ready, o1_en_a, o1_en_b, o1_rv, o1_cin}, '0);
        chk("async_rst_data", {o0_d_a, o0_d_b, o1_d_a, o1_d_b}, '0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        send_op(tbl[1], 1);

        // Back-to-back pairs with in_valid held high.
        begin
            int unsigned k, rv_seen;
            k = 0;
            rv_seen = rv_cnt;
            in_valid = 1'b1;
            for (int g = 0; g < 40 && (k < 8 || rv_cnt - rv_seen < 2); g++) begin
                in_data = 8'(k * 17 + 3);
                in_cin = k[0];
                if (o0_ready && k < 8) k++;
                if (k >= 8 && !o0_ready) in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b0;
            chk("b2b_rv_count", rv_cnt - rv_seen, 2);
            chk("b2b_rv_spacing", rv_last - rv_prev, 6);
        end

        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data = 8'($urandom);
            in_cin = 1'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
